sdram_host_queue: RTL and testbench

- Host-side front end placed directly upstream of sdram_controller.
- Buffers host read/write requests in a small FIFO and issues them one at a time on the controller's wr_enable/rd_enable/busy interface.
- Returns read data through a valid/ready response port.
- Decouples host timing from controller busy periods: init, refresh and access latency.

---
 rtl/sdram_host_queue.sv | 187 ++++++++++++++++++
 tb/tb_sdram_host_queue.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_queue.sv
// sdram_host_queue: host request FIFO and single-command issuer
// sitting in front of sdram_controller's enable/busy interface.
module sdram_host_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] ctl_wr_addr,
    output logic [DATA_W-1:0] ctl_wr_data,
    output logic              ctl_wr_enable,
    output logic              ctl_rd_enable,
    input  logic              ctl_busy,
    input  logic [DATA_W-1:0] ctl_rd_data,
    input  logic              ctl_rd_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    req_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t            state_q;
    logic              cmd_write_q;
    logic              captured_q;
    logic [ADDR_W-1:0] ctl_addr_q;
    logic [DATA_W-1:0] ctl_data_q;
    logic              ctl_wr_en_q;
    logic              ctl_rd_en_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic capture;
    req_t head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign push  = req_valid && !full;

    // A read waits while a response is still unconsumed; being FIFO,
    // that also stalls any writes queued behind it.
    assign pop = (state_q == IDLE) && !empty && !ctl_busy &&
                 (head.write || !rsp_valid_q);

    // First read-data strobe of the outstanding read only.
    assign capture = (state_q != IDLE) && !cmd_write_q &&
                     !captured_q && ctl_rd_ready;

    // Next-state for FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{write: req_write,
                                 addr:  req_addr,
                                 wdata: req_wdata};
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Issue FSM with registered controller-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_write_q <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_data_q  <= '0;
            ctl_wr_en_q <= 1'b0;
            ctl_rd_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q     <= ISSUE;
                        cmd_write_q <= head.write;
                        ctl_addr_q  <= head.addr;
                        ctl_data_q  <= head.write ? head.wdata : '0;
                        ctl_wr_en_q <= head.write;
                        ctl_rd_en_q <= !head.write;
                    end
                end
                ISSUE: begin
                    if (ctl_busy) begin
                        state_q     <= WAIT;
                        ctl_wr_en_q <= 1'b0;
                        ctl_rd_en_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!ctl_busy && (cmd_write_q || captured_q)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ctl_wr_en_q <= 1'b0;
                    ctl_rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Read-data capture and response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (pop) begin
                captured_q <= 1'b0;
            end else if (capture) begin
                captured_q <= 1'b1;
            end
            if (capture) begin
                rsp_data_q  <= ctl_rd_data;
                rsp_valid_q <= 1'b1;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign req_ready     = !full;
    assign count         = count_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign ctl_wr_addr   = ctl_addr_q;
    assign ctl_wr_data   = ctl_data_q;
    assign ctl_wr_enable = ctl_wr_en_q;
    assign ctl_rd_enable = ctl_rd_en_q;

endmodule

// File: tb/tb_sdram_host_queue.sv
// tb_sdram_host_queue: directed scenarios plus randomized traffic
// against a queue-based model of the host queue.
module tb_sdram_host_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] ctl_wr_addr;
    logic [DATA_W-1:0] ctl_wr_data;
    logic              ctl_wr_enable;
    logic              ctl_rd_enable;
    logic              ctl_busy = 1'b0;
    logic [DATA_W-1:0] ctl_rd_data = '0;
    logic              ctl_rd_ready = 1'b0;

    int vecs = 0;
    int errs = 0;

    sdram_host_queue #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .count        (count),
        .ctl_wr_addr  (ctl_wr_addr),
        .ctl_wr_data  (ctl_wr_data),
        .ctl_wr_enable(ctl_wr_enable),
        .ctl_rd_enable(ctl_rd_enable),
        .ctl_busy     (ctl_busy),
        .ctl_rd_data  (ctl_rd_data),
        .ctl_rd_ready (ctl_rd_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ctl_wr_enable || ctl_rd_enable) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic finish_cmd(input bit rd, input logic [DATA_W-1:0] rdat);
        ctl_busy = 1'b1;
        tick();
        if (rd) begin
            ctl_rd_data  = rdat;
            ctl_rd_ready = 1'b1;
            tick();
            ctl_rd_ready = 1'b0;
        end
        ctl_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vecs++;
        if ({count, req_ready, rsp_valid, rsp_data} !== {3'd0, 1'b1, 1'b0, 16'h0}) begin
            errs++;
            $display("FAIL reset_host got cnt=%0d rdy=%b v=%b d=%h want 0 1 0 0000",
                     count, req_ready, rsp_valid, rsp_data);
        end
        vecs++;
        if ({ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data} !== 42'h0) begin
            errs++;
            $display("FAIL reset_ctl got we=%b re=%b a=%h d=%h want all 0",
                     ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        push(1'b1, 24'hfedbed, 16'd3333);
        vecs++;
        if (ctl_wr_enable !== 1'b0 || count !== 3'd1) begin
            errs++;
            $display("FAIL wr_accept got we=%b cnt=%0d want 0 1", ctl_wr_enable, count);
        end
        tick();
        vecs++;
        if ({ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data, count} !==
            {1'b1, 1'b0, 24'hfedbed, 16'h0d05, 3'd0}) begin
            errs++;
            $display("FAIL wr_issue got we=%b re=%b a=%h d=%h cnt=%0d want 1 0 fedbed 0d05 0",
                     ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data, count);
        end
        tick();
        tick();
        vecs++;
        if (ctl_wr_enable !== 1'b1) begin
            errs++;
            $display("FAIL wr_hold got we=%b want 1", ctl_wr_enable);
        end
        ctl_busy = 1'b1;
        tick();
        vecs++;
        if (ctl_wr_enable !== 1'b0) begin
            errs++;
            $display("FAIL wr_drop got we=%b want 0", ctl_wr_enable);
        end
        ctl_busy = 1'b0;
        tick();
        tick();
        vecs++;
        if ({ctl_wr_enable, count, ctl_wr_addr} !== {1'b0, 3'd0, 24'hfedbed}) begin
            errs++;
            $display("FAIL wr_idle got we=%b cnt=%0d a=%h want 0 0 fedbed",
                     ctl_wr_enable, count, ctl_wr_addr);
        end
    endtask

    task automatic test_read();
        rsp_ready = 1'b0;
        push(1'b0, 24'hbedfed, 16'h1234);
        tick();
        vecs++;
        if ({ctl_rd_enable, ctl_wr_enable, ctl_wr_addr, ctl_wr_data} !==
            {1'b1, 1'b0, 24'hbedfed, 16'h0}) begin
            errs++;
            $display("FAIL rd_issue got re=%b we=%b a=%h d=%h want 1 0 bedfed 0000",
                     ctl_rd_enable, ctl_wr_enable, ctl_wr_addr, ctl_wr_data);
        end
        ctl_busy = 1'b1;
        tick();
        vecs++;
        if (ctl_rd_enable !== 1'b0 || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL rd_drop got re=%b v=%b want 0 0", ctl_rd_enable, rsp_valid);
        end
        ctl_rd_data  = 16'hbbbb;
        ctl_rd_ready = 1'b1;
        tick();
        ctl_rd_ready = 1'b0;
        ctl_rd_data  = 16'h0;
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hbbbb) begin
            errs++;
            $display("FAIL rd_capture got v=%b d=%h want 1 bbbb", rsp_valid, rsp_data);
        end
        ctl_busy = 1'b0;
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vecs++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'hbbbb) begin
            errs++;
            $display("FAIL rd_consume got v=%b d=%h want 0 bbbb", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_full();
        logic [ADDR_W-1:0] a [DEPTH];
        logic [DATA_W-1:0] d [DEPTH];
        bit ok;
        ctl_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            a[i] = {8'(i + 1), 16'($urandom)};
            d[i] = 16'($urandom);
            push(1'b1, a[i], d[i]);
        end
        vecs++;
        if (count !== 3'd4 || req_ready !== 1'b0) begin
            errs++;
            $display("FAIL full_state got cnt=%0d rdy=%b want 4 0", count, req_ready);
        end
        push(1'b1, 24'h0, 16'hdead);
        vecs++;
        if (count !== 3'd4) begin
            errs++;
            $display("FAIL full_reject got cnt=%0d want 4", count);
        end
        ctl_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            wait_en(ok);
            vecs++;
            if (!ok || {ctl_wr_enable, ctl_wr_addr, ctl_wr_data, count} !==
                {1'b1, a[k], d[k], 3'(DEPTH - 1 - k)}) begin
                errs++;
                $display("FAIL full_drain%0d got ok=%b we=%b a=%h d=%h cnt=%0d want 1 1 %h %h %0d",
                         k, ok, ctl_wr_enable, ctl_wr_addr, ctl_wr_data, count,
                         a[k], d[k], DEPTH - 1 - k);
            end
            finish_cmd(1'b0, 16'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] aa, ab;
        logic [DATA_W-1:0] da, db;
        bit ok;
        aa = 24'h100000 | 24'($urandom_range(0, 16'hffff));
        ab = 24'h200000 | 24'($urandom_range(0, 16'hffff));
        da = 16'($urandom);
        db = ~da;
        rsp_ready = 1'b0;
        push(1'b0, aa, 16'h0);
        push(1'b0, ab, 16'h0);
        wait_en(ok);
        vecs++;
        if (!ok || ctl_rd_enable !== 1'b1 || ctl_wr_addr !== aa) begin
            errs++;
            $display("FAIL bp_issue_a got ok=%b re=%b a=%h want 1 1 %h",
                     ok, ctl_rd_enable, ctl_wr_addr, aa);
        end
        finish_cmd(1'b1, da);
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++;
            if ({ctl_rd_enable, rsp_valid, rsp_data, count} !== {1'b0, 1'b1, da, 3'd1}) begin
                errs++;
                $display("FAIL bp_hold%0d got re=%b v=%b d=%h cnt=%0d want 0 1 %h 1",
                         i, ctl_rd_enable, rsp_valid, rsp_data, count, da);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wait_en(ok);
        vecs++;
        if (!ok || ctl_rd_enable !== 1'b1 || ctl_wr_addr !== ab || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_issue_b got ok=%b re=%b a=%h v=%b want 1 1 %h 0",
                     ok, ctl_rd_enable, ctl_wr_addr, rsp_valid, ab);
        end
        finish_cmd(1'b1, db);
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_data !== db) begin
            errs++;
            $display("FAIL bp_rsp_b got v=%b d=%h want 1 %h", rsp_valid, rsp_data, db);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        ctl_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 24'(32'h300 + i), 16'(i));
        end
        ctl_busy = 1'b0;
        wait_en(ok);
        vecs++;
        if (!ok || ctl_wr_enable !== 1'b1 || count !== 3'd2) begin
            errs++;
            $display("FAIL rm_issue got ok=%b we=%b cnt=%0d want 1 1 2", ok, ctl_wr_enable, count);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({ctl_wr_enable, ctl_rd_enable, count, rsp_valid, req_ready} !==
            {1'b0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL rm_async got we=%b re=%b cnt=%0d v=%b rdy=%b want 0 0 0 0 1",
                     ctl_wr_enable, ctl_rd_enable, count, rsp_valid, req_ready);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (ctl_wr_enable !== 1'b0 || ctl_rd_enable !== 1'b0) begin
                errs++;
                $display("FAIL rm_quiet%0d got we=%b re=%b want 0 0",
                         i, ctl_wr_enable, ctl_rd_enable);
            end
        end
        push(1'b1, 24'h0abcde, 16'h5a5a);
        wait_en(ok);
        vecs++;
        if (!ok || ctl_wr_addr !== 24'h0abcde || ctl_wr_data !== 16'h5a5a) begin
            errs++;
            $display("FAIL rm_new got ok=%b a=%h d=%h want 1 0abcde 5a5a",
                     ok, ctl_wr_addr, ctl_wr_data);
        end
        finish_cmd(1'b0, 16'h0);
    endtask

    task automatic test_simul();
        cmd_t q[$];
        cmd_t c;
        bit ok;
        for (int it = 0; it < 5; it++) begin
            ctl_busy = 1'b1;
            for (int i = 0; i < 2; i++) begin
                c = {1'b1, 24'($urandom), 16'($urandom)};
                q.push_back(c);
                push(c.w, c.a, c.d);
            end
            c = {1'b1, 24'($urandom), 16'($urandom)};
            q.push_back(c);
            ctl_busy  = 1'b0;
            req_valid = 1'b1;
            req_write = c.w;
            req_addr  = c.a;
            req_wdata = c.d;
            tick();
            req_valid = 1'b0;
            vecs++;
            if (count !== 3'd2) begin
                errs++;
                $display("FAIL sim_count%0d got %0d want 2", it, count);
            end
            while (q.size() != 0) begin
                c = q.pop_front();
                wait_en(ok);
                vecs++;
                if (!ok || {ctl_wr_enable, ctl_wr_addr, ctl_wr_data} !== {c.w, c.a, c.d}) begin
                    errs++;
                    $display("FAIL sim_order%0d got ok=%b a=%h d=%h want %h %h",
                             it, ok, ctl_wr_addr, ctl_wr_data, c.a, c.d);
                end
                finish_cmd(1'b0, 16'h0);
            end
        end
    endtask

    task automatic test_random();
        cmd_t        q[$];
        logic [15:0] rq[$];
        logic [15:0] last = '0;
        cmd_t        c, got;
        bit          is_rd = 0, strobed = 0, seen = 0, pre_v, rr;
        int          ph = 0, dly = 0, cyc = 0;
        while (cyc < 3000 && (cyc < 400 || q.size() != 0 || ph != 0 || rsp_valid)) begin
            if (cyc < 400) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 24'($urandom);
                req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            rr = ($urandom_range(0, 2) != 0);
            rsp_ready = rr;
            pre_v = rsp_valid;
            ctl_rd_ready = 1'b0;
            if (ph == 0) begin
                ctl_busy = ($urandom_range(0, 7) == 0);
            end else if (ph == 1) begin
                if (dly == 0) begin
                    ctl_busy = 1'b1;
                    ph = 2;
                    dly = $urandom_range(2, 4);
                end else begin
                    dly--;
                end
            end else begin
                if (is_rd && !strobed && !ctl_rd_enable) begin
                    ctl_rd_data  = 16'($urandom);
                    ctl_rd_ready = 1'b1;
                    rq.push_back(ctl_rd_data);
                    strobed = 1;
                end else if (is_rd && strobed && $urandom_range(0, 2) == 0) begin
                    ctl_rd_data  = 16'($urandom);
                    ctl_rd_ready = 1'b1;
                end
                if (dly == 0) begin
                    ctl_busy = 1'b0;
                    ph = 0;
                end else begin
                    dly--;
                end
            end
            if (req_valid && req_ready) begin
                q.push_back({req_write, req_addr, req_write ? req_wdata : 16'h0});
            end
            tick();
            cyc++;
            if (pre_v && rr) seen = 0;
            if ((ctl_wr_enable || ctl_rd_enable) && ph == 0) begin
                got = {ctl_wr_enable, ctl_wr_addr, ctl_wr_data};
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL rnd_spurious got a=%h want no command", ctl_wr_addr);
                end else begin
                    c = q.pop_front();
                    if (got !== c || (ctl_wr_enable && ctl_rd_enable)) begin
                        errs++;
                        $display("FAIL rnd_cmd got w=%b a=%h d=%h want w=%b a=%h d=%h",
                                 got.w, got.a, got.d, c.w, c.a, c.d);
                    end
                end
                is_rd = ctl_rd_enable;
                strobed = 0;
                ph = 1;
                dly = $urandom_range(0, 3);
            end
            vecs++;
            if (count !== CNT_W'(q.size()) || req_ready !== (q.size() < DEPTH)) begin
                errs++;
                $display("FAIL rnd_occ got cnt=%0d rdy=%b want %0d %b",
                         count, req_ready, q.size(), q.size() < DEPTH);
            end
            if (rsp_valid && !seen) begin
                vecs++;
                if (rq.size() == 0) begin
                    errs++;
                    $display("FAIL rnd_rsp got d=%h want no response", rsp_data);
                end else begin
                    last = rq.pop_front();
                    if (rsp_data !== last) begin
                        errs++;
                        $display("FAIL rnd_rsp got d=%h want %h", rsp_data, last);
                    end
                end
                seen = 1;
            end else if (rsp_valid) begin
                vecs++;
                if (rsp_data !== last) begin
                    errs++;
                    $display("FAIL rnd_rsp_hold got d=%h want %h", rsp_data, last);
                end
            end
        end
        ctl_busy = 1'b0;
        ctl_rd_ready = 1'b0;
        rsp_ready = 1'b0;
        vecs++;
        if (q.size() != 0 || ph != 0 || rq.size() != 0) begin
            errs++;
            $display("FAIL rnd_drain got q=%0d ph=%0d rq=%0d want 0 0 0",
                     q.size(), ph, rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_simul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
